// File: rtl/spi_write_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus write bridge.
package spi_write_bridge_pkg;

  localparam int unsigned BYTE_BITS       = 8;
  localparam int unsigned MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } rx_state_e;

  typedef enum logic [1:0] {
    WIDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampled SPI mode-0 byte receiver: synchronisers, SCK edge detect,
// MSB-first shift register and bit counter. byte_done_o pulses for one
// cycle, aligned with byte_o, in the cycle the bit counter wraps.
module spi_byte_rx
  import spi_write_bridge_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sck_i,
  input  logic                 mosi_i,
  input  logic                 cs_n_i,
  output logic                 cs_n_sync_o,
  output logic                 byte_done_o,
  output logic [BYTE_BITS-1:0] byte_o
);

  localparam int unsigned STAGES = (SyncStages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SyncStages;
  localparam int unsigned CNT_W  = $clog2(BYTE_BITS);

  logic [STAGES-1:0]    sck_sync_q, mosi_sync_q, cs_sync_q;
  logic                 sck_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BYTE_BITS-1:0] shift_q, shift_d;
  logic                 byte_done_q, byte_done_d;
  logic                 sck_s, mosi_s, cs_n_s, sample_c;

  assign sck_s    = sck_sync_q[STAGES-1];
  assign mosi_s   = mosi_sync_q[STAGES-1];
  assign cs_n_s   = cs_sync_q[STAGES-1];
  assign sample_c = sck_s & ~sck_prev_q & ~cs_n_s;

  // Synchronise the SPI pins and remember last synced SCK for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[STAGES-2:0], sck_i};
      mosi_sync_q <= {mosi_sync_q[STAGES-2:0], mosi_i};
      cs_sync_q   <= {cs_sync_q[STAGES-2:0], cs_n_i};
      sck_prev_q  <= sck_s;
    end
  end

  // Shift in one bit per SCK rising edge; deselect discards any partial byte.
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    if (cs_n_s) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (sample_c) begin
      shift_d     = {shift_q[BYTE_BITS-2:0], mosi_s};
      cnt_d       = cnt_q + CNT_W'(1);
      byte_done_d = (cnt_q == CNT_W'(BYTE_BITS - 1));
    end
  end

  // Receiver state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign cs_n_sync_o = cs_n_s;
  assign byte_done_o = byte_done_q;
  assign byte_o      = shift_q;

endmodule

// File: rtl/spi_write_bridge.sv
// SPI-slave to register-bus write bridge. First byte of a frame is the
// register address, each following byte is written with an active-low
// _Write strobe. Define SPI_ADDR_AUTOINC_EN to advance the address after
// every write so consecutive data bytes land in consecutive registers.
module spi_write_bridge
  import spi_write_bridge_pkg::*;
#(
  parameter int unsigned AddressWidth = 8,
  parameter int unsigned StrobeCycles = 2,
  parameter int unsigned SyncStages   = 2
) (
  input  logic                    CLK,
  input  logic                    _RST,
  input  logic                    SCK,
  input  logic                    MOSI,
  input  logic                    _CS,
  output logic [AddressWidth-1:0] AddressBus,
  output logic [BYTE_BITS-1:0]    DataOut,
  output logic                    _Write,
  output logic                    Busy
);

  localparam int unsigned SC_W = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  logic                    cs_n_s, byte_done;
  logic [BYTE_BITS-1:0]    rx_byte;

  rx_state_e               rx_state_q, rx_state_d;
  wr_state_e               wr_state_q, wr_state_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [BYTE_BITS-1:0]    data_q, data_d;
  logic [SC_W-1:0]         strobe_cnt_q, strobe_cnt_d;
  logic [AddressWidth-1:0] addr_out_q, addr_out_d;
  logic [BYTE_BITS-1:0]    data_out_q, data_out_d;
  logic                    write_n_q, write_n_d;
  logic                    busy_q, busy_d;
  logic                    addr_ld_c, wr_req_c;

  spi_byte_rx #(
    .SyncStages(SyncStages)
  ) u_rx (
    .clk        (CLK),
    .rst_n      (_RST),
    .sck_i      (SCK),
    .mosi_i     (MOSI),
    .cs_n_i     (_CS),
    .cs_n_sync_o(cs_n_s),
    .byte_done_o(byte_done),
    .byte_o     (rx_byte)
  );

  // Receive FSM: a byte that completed just before deselect is still honoured.
  always_comb begin
    rx_state_d = rx_state_q;
    data_d     = data_q;
    addr_ld_c  = 1'b0;
    wr_req_c   = 1'b0;
    case (rx_state_q)
      IDLE: if (!cs_n_s) rx_state_d = ADDR;
      ADDR: if (byte_done) begin
        addr_ld_c  = 1'b1;
        rx_state_d = DATA;
      end
      DATA: if (byte_done) begin
        data_d   = rx_byte;
        wr_req_c = 1'b1;
      end
      default: rx_state_d = IDLE;
    endcase
    if (cs_n_s) rx_state_d = IDLE;
  end

  // Address register: loaded by an address byte, optionally advanced after each write.
  always_comb begin
    addr_d = addr_q;
`ifdef SPI_ADDR_AUTOINC_EN
    if (wr_state_q == HOLD) addr_d = addr_q + AddressWidth'(1);
`endif
    if (addr_ld_c) addr_d = rx_byte[AddressWidth-1:0];
  end

  // Write FSM: SETUP, StrobeCycles of STROBE, HOLD; outputs follow the next state.
  always_comb begin
    wr_state_d   = wr_state_q;
    strobe_cnt_d = strobe_cnt_q;
    addr_out_d   = addr_out_q;
    data_out_d   = data_out_q;
    case (wr_state_q)
      WIDLE: if (wr_req_c) begin
        wr_state_d = SETUP;
        addr_out_d = addr_q;
        data_out_d = data_d;
      end
      SETUP: begin
        wr_state_d   = STROBE;
        strobe_cnt_d = '0;
      end
      STROBE: begin
        if (strobe_cnt_q == SC_W'(StrobeCycles - 1)) wr_state_d = HOLD;
        else strobe_cnt_d = strobe_cnt_q + SC_W'(1);
      end
      HOLD:    wr_state_d = WIDLE;
      default: wr_state_d = WIDLE;
    endcase
    write_n_d = (wr_state_d != STROBE);
    busy_d    = (wr_state_d != WIDLE);
  end

  // State and output registers; reset releases _Write without waiting for CLK.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      rx_state_q   <= IDLE;
      wr_state_q   <= WIDLE;
      addr_q       <= '0;
      data_q       <= '0;
      strobe_cnt_q <= '0;
      addr_out_q   <= '0;
      data_out_q   <= '0;
      write_n_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      wr_state_q   <= wr_state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      strobe_cnt_q <= strobe_cnt_d;
      addr_out_q   <= addr_out_d;
      data_out_q   <= data_out_d;
      write_n_q    <= write_n_d;
      busy_q       <= busy_d;
    end
  end

  assign AddressBus = addr_out_q;
  assign DataOut    = data_out_q;
  assign _Write     = write_n_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_spi_write_bridge.sv
// Self-checking bench for spi_write_bridge: table-driven frames plus
// hand-written abort, late-deselect and reset-during-strobe sequences.
module tb_spi_write_bridge;

  localparam int unsigned AW = 8;
  localparam int unsigned SC = 2;

  logic          CLK = 1'b0;
  logic          _RST;
  logic          SCK;
  logic          MOSI;
  logic          _CS;
  logic [AW-1:0] AddressBus;
  logic [7:0]    DataOut;
  logic          _Write;
  logic          Busy;

  int n_cmp = 0;
  int n_err = 0;

  spi_write_bridge #(
    .AddressWidth(AW),
    .StrobeCycles(SC),
    .SyncStages  (2)
  ) dut (
    .CLK       (CLK),
    ._RST      (_RST),
    .SCK       (SCK),
    .MOSI      (MOSI),
    ._CS       (_CS),
    .AddressBus(AddressBus),
    .DataOut   (DataOut),
    ._Write    (_Write),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // Observed write transactions.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         lowc;
    bit         stable;
    bit         busy_ok;
  } wr_rec_t;

  wr_rec_t got[$];
  wr_rec_t cur;
  bit         in_low = 0;
  logic       prev_w = 1'b1;
  logic [7:0] prev_a = '0;
  logic [7:0] prev_d = '0;
  logic       prev_busy = 1'b0;

  // Monitor: capture each _Write pulse, its width and bus stability around it.
  always @(negedge CLK) begin
    if (!_RST) begin
      in_low = 0;
      prev_w = 1'b1;
    end else begin
      if (prev_w && !_Write) begin
        cur.a       = AddressBus;
        cur.d       = DataOut;
        cur.lowc    = 1;
        cur.stable  = (AddressBus == prev_a) && (DataOut == prev_d);
        cur.busy_ok = Busy && prev_busy;
        in_low      = 1;
      end else if (in_low && !_Write) begin
        cur.lowc++;
        if (AddressBus != cur.a || DataOut != cur.d) cur.stable = 0;
        if (!Busy) cur.busy_ok = 0;
      end else if (in_low && _Write) begin
        if (AddressBus != cur.a || DataOut != cur.d) cur.stable = 0;
        if (!Busy) cur.busy_ok = 0;
        got.push_back(cur);
        in_low = 0;
      end
      prev_w    = _Write;
      prev_a    = AddressBus;
      prev_d    = DataOut;
      prev_busy = Busy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Send the top nbits of b, MSB first, SCK period 8 CLK.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK) MOSI = b[7-i];
      repeat (3) @(negedge CLK);
      SCK = 1'b1;
      repeat (4) @(negedge CLK);
      SCK = 1'b0;
    end
  endtask

  task automatic start_frame();
    @(negedge CLK) _CS = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic end_frame();
    @(negedge CLK) _CS = 1'b1;
    repeat (40) @(negedge CLK);
  endtask

  task automatic check_write(input string tag, input int k, input logic [7:0] ea, input logic [7:0] ed);
    if (k < got.size()) begin
      check({tag, "_addr"}, 32'(got[k].a), 32'(ea));
      check({tag, "_data"}, 32'(got[k].d), 32'(ed));
      check({tag, "_width"}, 32'(got[k].lowc), 32'(SC));
      check({tag, "_stable"}, 32'(got[k].stable), 32'd1);
      check({tag, "_busy"}, 32'(got[k].busy_ok), 32'd1);
    end
  endtask

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    int          nw;
    logic [23:0] ea;
    logic [23:0] ed;
  } vec_t;

  vec_t vecs[3];

  initial begin
    bit found;

    vecs[0] = '{bytes: 32'h03A5_0000, nb: 2, nw: 1, ea: 24'h03_0000, ed: 24'hA5_0000};
`ifdef SPI_ADDR_AUTOINC_EN
    vecs[1] = '{bytes: 32'h0411_2233, nb: 4, nw: 3, ea: 24'h04_0506, ed: 24'h11_2233};
    vecs[2] = '{bytes: 32'hFF01_0200, nb: 3, nw: 2, ea: 24'hFF_0000, ed: 24'h01_0200};
`else
    vecs[1] = '{bytes: 32'h0411_2233, nb: 4, nw: 3, ea: 24'h04_0404, ed: 24'h11_2233};
    vecs[2] = '{bytes: 32'hFF01_0200, nb: 3, nw: 2, ea: 24'hFFFF_00, ed: 24'h01_0200};
`endif

    // Reset
    _RST = 1'b0; SCK = 1'b0; MOSI = 1'b0; _CS = 1'b1;
    repeat (5) @(negedge CLK);
    _RST = 1'b1;
    @(negedge CLK);
    check("rst_addr", 32'(AddressBus), 32'h0);
    check("rst_data", 32'(DataOut), 32'h0);
    check("rst_write", 32'(_Write), 32'h1);
    check("rst_busy", 32'(Busy), 32'h0);

    // Table-driven frames
    for (int t = 0; t < 3; t++) begin
      got.delete();
      start_frame();
      for (int j = 0; j < vecs[t].nb; j++) send_bits(vecs[t].bytes[31-8*j -: 8], 8);
      end_frame();
      check($sformatf("v%0d_count", t), 32'(got.size()), 32'(vecs[t].nw));
      for (int k = 0; k < vecs[t].nw; k++)
        check_write($sformatf("v%0d_w%0d", t, k), k, vecs[t].ea[23-8*k -: 8], vecs[t].ed[23-8*k -: 8]);
      check($sformatf("v%0d_idle_busy", t), 32'(Busy), 32'h0);
      check($sformatf("v%0d_idle_write", t), 32'(_Write), 32'h1);
    end

    // Abort inside a data byte: only the complete byte is written
    got.delete();
    start_frame();
    send_bits(8'h02, 8);
    send_bits(8'h7E, 8);
    send_bits(8'hFF, 5);
    end_frame();
    check("abort_data_count", 32'(got.size()), 32'd1);
    check_write("abort_data_w0", 0, 8'h02, 8'h7E);
    check("abort_data_bus", 32'(AddressBus), 32'h02);

    // Abort inside an address byte: no write, bus untouched
    got.delete();
    start_frame();
    send_bits(8'h5A, 3);
    end_frame();
    check("abort_addr_count", 32'(got.size()), 32'd0);
    check("abort_addr_bus", 32'(AddressBus), 32'h02);
    check("abort_addr_data", 32'(DataOut), 32'h7E);

    // Deselect one CLK after the last data bit: the write still completes
    got.delete();
    start_frame();
    send_bits(8'h01, 8);
    send_bits(8'hC3, 7);
    @(negedge CLK) MOSI = 1'b1;
    repeat (3) @(negedge CLK);
    SCK = 1'b1;
    @(negedge CLK) _CS = 1'b1;
    repeat (3) @(negedge CLK);
    SCK = 1'b0;
    repeat (40) @(negedge CLK);
    check("late_cs_count", 32'(got.size()), 32'd1);
    check_write("late_cs_w0", 0, 8'h01, 8'hC3);
    check("late_cs_busy", 32'(Busy), 32'h0);

    // Reset asserted during STROBE releases _Write without a clock edge
    got.delete();
    start_frame();
    send_bits(8'h05, 8);
    send_bits(8'h66, 7);
    @(negedge CLK) MOSI = 1'b0;
    repeat (3) @(negedge CLK);
    SCK = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (!_Write) found = 1;
    end
    check("strobe_seen", 32'(found), 32'd1);
    #2 _RST = 1'b0;
    #1;
    check("rst_mid_write", 32'(_Write), 32'h1);
    check("rst_mid_busy", 32'(Busy), 32'h0);
    check("rst_mid_addr", 32'(AddressBus), 32'h0);
    check("rst_mid_data", 32'(DataOut), 32'h0);
    SCK = 1'b0;
    _CS = 1'b1;
    repeat (5) @(negedge CLK);
    _RST = 1'b1;
    repeat (5) @(negedge CLK);
    check("post_rst_write", 32'(_Write), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_write_bridge.md
Name: spi_write_bridge

Overview:
- SPI-slave front end that turns serial frames into register-bus writes (AddressBus, DataOut, _Write) for the PWM/IO register banks.
- First byte of a frame is the address; each following byte is a data write.
- Runs entirely on the system clock CLK; the SPI pins are oversampled, never used as clocks.
- Generates the active-low _Write strobe the register banks capture on.

Parameters:
- AddressWidth, 8, width of AddressBus; legal range 1..8; the low AddressWidth bits of the address byte are used.
- StrobeCycles, 2, number of CLK cycles _Write is held low per write; minimum 1.
- SyncStages, 2, flip-flop synchroniser depth on SCK, MOSI and _CS; minimum 2.

Ports:
- CLK  in  1  system clock, all state on posedge.
- _RST  in  1  reset; asynchronous, active-low.
- SCK  in  1  SPI clock, mode 0 (idle low, sample on rising edge); frequency at most CLK/4.
- MOSI  in  1  serial data, MSB first.
- _CS  in  1  active-low frame select.
- AddressBus  out  AddressWidth  register address to the register banks.
- DataOut  out  8  write data; drives the register banks' DataIn.
- _Write  out  1  active-low write strobe; registers capture on its falling edge.
- Busy  out  1  high while a write sequence (SETUP/STROBE/HOLD) is in progress.

Behaviour:
- Reset (_RST low, asynchronous): AddressBus=0, DataOut=0, _Write=1, Busy=0.
  - Both FSMs go to IDLE; bit counter and shift register are cleared.
  - Reset mid-strobe releases _Write high immediately and does not wait for CLK.
- Input sync and sampling:
  - SCK, MOSI and _CS each pass through SyncStages flops.
  - An SCK rising edge is detected as synced SCK low in the previous cycle and high in the current cycle.
  - On that edge, when synced _CS is low, the synced MOSI value is shifted into the LSB of an 8-bit shift register, and a 3-bit bit counter increments (wrapping 7->0).
  - A completed byte is flagged in the cycle the counter wraps.
- Receive FSM states:
  - IDLE: entered on reset or when synced _CS is high. Bit counter is held at 0.
  - IDLE -> ADDR on the synced _CS falling edge.
  - ADDR, byte complete: latch the address byte low bits into the address register, then go to DATA.
  - DATA, byte complete: copy the byte into the data buffer and pulse a one-cycle write request. Stay in DATA.
  - Synced _CS rising in any state: go to IDLE and discard the partial byte.
    - A partial byte never causes a write.
    - A partial address byte leaves the address register unchanged.
- Write FSM states:
  - WIDLE -> SETUP on a write request.
  - SETUP (1 cycle): drive AddressBus and DataOut from the address register and data buffer; _Write stays 1.
  - STROBE (StrobeCycles cycles): _Write=0.
  - HOLD (1 cycle): _Write=1. AddressBus and DataOut stay unchanged.
  - HOLD -> WIDLE.
  - Busy=1 in SETUP, STROBE and HOLD.
- Write sequence timing:
  - Latency from byte completion to the _Write falling edge is 2 CLK cycles (request cycle + SETUP).
  - AddressBus and DataOut are stable from SETUP through HOLD inclusive.
  - Between writes, AddressBus and DataOut keep their last values.
- Overlap: a full byte takes at least 32 CLK cycles, and a write sequence takes StrobeCycles+2 cycles. A request during Busy therefore cannot occur when StrobeCycles<=29; this is a design constraint and is not handled.
- _CS deasserting while Busy: the in-flight write completes normally.
- A new frame may start while Busy; its address byte cannot complete before HOLD ends.

Optional Feature:
- Macro: SPI_ADDR_AUTOINC_EN.
- Defined: the address register increments by 1 in HOLD of every write. It wraps modulo 2^AddressWidth, so with AddressWidth=8, 0xFF+1=0x00. Consecutive data bytes in a frame go to consecutive registers.
- Undefined: the address register changes only on an address byte. All data bytes in a frame write the same address.

Decomposition:
- Package spi_write_bridge_pkg holds:
  - rx state enum {IDLE, ADDR, DATA};
  - write state enum {WIDLE, SETUP, STROBE, HOLD};
  - BYTE_BITS=8;
  - MIN_SYNC_STAGES=2.
- Sub-module spi_byte_rx holds the synchronisers, SCK edge detect, shift register and bit counter. Its outputs are the synced _CS, a byte_done pulse and byte[7:0].
- The top level holds both FSMs and the address/data registers.

Test Plan:
- Reset: hold _RST low 5 cycles, then release -> AddressBus=0x00, DataOut=0x00, _Write=1, Busy=0. Assert _RST low during STROBE -> _Write=1 within the same cycle, no clock edge required.
- Single write at SCK=CLK/8: frame 0x03,0xA5 -> exactly one _Write low pulse of StrobeCycles=2 cycles, with AddressBus=0x03 and DataOut=0xA5 stable from 1 cycle before the falling edge until 1 cycle after the rising edge.
- Burst, with macro defined: frame 0x04,0x11,0x22,0x33 -> writes (0x04,0x11), (0x05,0x22), (0x06,0x33). Without the macro: all three writes go to 0x04.
- Wrap: macro defined, frame 0xFF,0x01,0x02 -> writes (0xFF,0x01) then (0x00,0x02).
- Aborts:
  - _CS raised after 5 bits of the data byte following 0x02,0x7E -> only the (0x02,0x7E) write occurs.
  - _CS raised after 3 bits of an address byte -> no write, and AddressBus is unchanged.
- _CS raised 1 CLK after the final data bit of 0x01,0xC3 -> the write (0x01,0xC3) still completes with a full strobe, and Busy returns to 0 after HOLD.
